// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the fetch-stage program counter.
//   pc_state_e  - controller state (BOOT / RUN / BUBBLE)
//   redirect_e  - why the PC is being redirected this cycle
//   DEF_*       - default reset and trap vectors
//   is_vectored - true when a redirect jumps to the trap vector
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    RD_NONE     = 2'd0,
    RD_BRANCH   = 2'd1,
    RD_TRAP     = 2'd2,
    RD_MISALIGN = 2'd3
  } redirect_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0080;

  // Traps and misaligned branches both land on the trap vector and save epc.
  function automatic logic is_vectored(input redirect_e cause);
    return (cause == RD_TRAP) || (cause == RD_MISALIGN);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
//   clk   - clock (falling-edge, matching the fetch stage)
//   rst_n - asynchronous active-low reset to zero
//   srst  - synchronous clear
//   en    - count enable
//   count - registered count value
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         srst,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Count register: clear on reset, hold at all-ones once reached.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (srst) begin
      count_r <= '0;
    end else if (en && (count_r != {W{1'b1}})) begin
      count_r <= count_r + W'(1);
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-stage program counter with reset/trap vectors, stall hold,
// branch redirect, trap redirect with epc capture, post-redirect fetch
// bubbles, sticky misaligned-branch flag and a saturating fetch counter.
// All state changes on the falling edge of clk.
//   clk, reset (async, active-low)
//   stall, br_taken, br_target, trap - control inputs
//   PCout       - current fetch address
//   pc_next     - combinational next PC
//   fetch_valid - PCout is a real fetch
//   epc         - PC saved on the last trap / misaligned branch
//   misalign    - sticky misaligned-branch flag
//   fetch_count - saturating count of completed fetches
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int                 WIDTH         = 32,
  parameter logic [WIDTH-1:0]   RESET_VECTOR  = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0]   TRAP_VECTOR   = WIDTH'(DEF_TRAP_VECTOR),
  parameter int                 INC           = 4,
  parameter int                 ALIGN_BITS    = 2,
  parameter int                 BUBBLE_CYCLES = 1,
  parameter int                 CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 br_taken,
  input  logic [WIDTH-1:0]     br_target,
  input  logic                 trap,
  output logic [WIDTH-1:0]     PCout,
  output logic [WIDTH-1:0]     pc_next,
  output logic                 fetch_valid,
  output logic [WIDTH-1:0]     epc,
  output logic                 misalign,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  // Mask form avoids an empty slice when ALIGN_BITS is 0.
  localparam logic [WIDTH-1:0] ALIGN_MASK  = ~({WIDTH{1'b1}} << ALIGN_BITS);
  localparam logic [WIDTH-1:0] INC_W       = WIDTH'(INC);
  localparam logic [3:0]       BUBBLE_LOAD = 4'(BUBBLE_CYCLES);

  pc_state_e        state_r;
  logic [WIDTH-1:0] pc_r;
  logic             valid_r;
  logic [WIDTH-1:0] epc_r;
  logic             misalign_r;
  logic [3:0]       bub_cnt_r;

  redirect_e        cause_s;
  logic [WIDTH-1:0] pc_next_s;
  logic             fetch_en_s;

  // Redirect cause and next-PC mux; priority trap > branch > stall > increment.
  always_comb begin
    cause_s   = RD_NONE;
    pc_next_s = pc_r;
    case (state_r)
      BOOT: begin
        cause_s   = RD_NONE;
        pc_next_s = pc_r;
      end
      RUN: begin
        if (trap) begin
          cause_s   = RD_TRAP;
          pc_next_s = TRAP_VECTOR;
        end else if (br_taken && ((br_target & ALIGN_MASK) != '0)) begin
          cause_s   = RD_MISALIGN;
          pc_next_s = TRAP_VECTOR;
        end else if (br_taken) begin
          cause_s   = RD_BRANCH;
          pc_next_s = br_target;
        end else if (stall) begin
          cause_s   = RD_NONE;
          pc_next_s = pc_r;
        end else begin
          cause_s   = RD_NONE;
          pc_next_s = pc_r + INC_W;
        end
      end
      BUBBLE: begin
        // Branches are already squashed here; only a trap can move the PC.
        if (trap) begin
          cause_s   = RD_TRAP;
          pc_next_s = TRAP_VECTOR;
        end else begin
          cause_s   = RD_NONE;
          pc_next_s = pc_r;
        end
      end
      default: begin
        cause_s   = RD_NONE;
        pc_next_s = pc_r;
      end
    endcase
  end

  // A fetch completes when a valid, unstalled, non-redirected RUN cycle ends.
  always_comb begin
    if (valid_r && !stall && (cause_s == RD_NONE) && (state_r == RUN)) begin
      fetch_en_s = 1'b1;
    end else begin
      fetch_en_s = 1'b0;
    end
  end

  // PC controller state machine with registered outputs.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= BOOT;
      pc_r       <= RESET_VECTOR;
      valid_r    <= 1'b0;
      epc_r      <= '0;
      misalign_r <= 1'b0;
      bub_cnt_r  <= 4'd0;
    end else begin
      case (state_r)
        BOOT: begin
          // First fetch happens at the reset vector itself.
          state_r <= RUN;
          valid_r <= 1'b1;
        end
        RUN: begin
          pc_r <= pc_next_s;
          if (cause_s != RD_NONE) begin
            if (is_vectored(cause_s)) begin
              epc_r <= pc_r;
            end
            if (cause_s == RD_MISALIGN) begin
              misalign_r <= 1'b1;
            end
            if (BUBBLE_LOAD != 4'd0) begin
              valid_r   <= 1'b0;
              bub_cnt_r <= BUBBLE_LOAD;
              state_r   <= BUBBLE;
            end else begin
              valid_r <= 1'b1;
            end
          end
        end
        BUBBLE: begin
          pc_r <= pc_next_s;
          if (cause_s == RD_TRAP) begin
            epc_r     <= pc_r;
            bub_cnt_r <= BUBBLE_LOAD;
          end else if (bub_cnt_r == 4'd1) begin
            state_r   <= RUN;
            valid_r   <= 1'b1;
            bub_cnt_r <= 4'd0;
          end else begin
            bub_cnt_r <= bub_cnt_r - 4'd1;
          end
        end
        default: begin
          state_r <= BOOT;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_WIDTH)) u_fetch_cnt (
    .clk   (clk),
    .rst_n (reset),
    .srst  (1'b0),
    .en    (fetch_en_s),
    .count (fetch_count)
  );

  assign PCout       = pc_r;
  assign pc_next     = pc_next_s;
  assign fetch_valid = valid_r;
  assign epc         = epc_r;
  assign misalign    = misalign_r;

endmodule
